// File: rtl/audioport_pkg.sv
// Shared types and register map for the audioport APB initiator.
package audioport_pkg;

   // APB3 transfer phases.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   // Audioport control-unit register map (byte addresses).
   localparam logic [31:0] AUDIOPORT_APB_BASE   = 32'h8c00_0000;
   localparam logic [31:0] CMD_REG_APB_ADDRESS  = AUDIOPORT_APB_BASE + 32'h0;
   localparam logic [31:0] STATUS_REG_APB_ADDRESS = AUDIOPORT_APB_BASE + 32'h4;
   localparam logic [31:0] LEVEL_REG_APB_ADDRESS  = AUDIOPORT_APB_BASE + 32'h8;
   localparam logic [31:0] CFG_REG_APB_ADDRESS  = AUDIOPORT_APB_BASE + 32'hC;

endpackage

// File: rtl/audioport_apb_master_if.sv
// Command/response handshake plus APB3 bus of the audioport initiator.
// master: the initiator (DUT) view; slave: the command source / APB slave view.
interface audioport_apb_master_if;

   logic        cmd_valid_in;
   logic        cmd_ready_out;
   logic        cmd_write_in;
   logic [31:0] cmd_addr_in;
   logic [31:0] cmd_wdata_in;

   logic        rsp_valid_out;
   logic [31:0] rsp_rdata_out;
   logic        rsp_slverr_out;
   logic        rsp_timeout_out;

   logic        psel_out;
   logic        penable_out;
   logic        pwrite_out;
   logic [31:0] paddr_out;
   logic [31:0] pwdata_out;
   logic [31:0] prdata_in;
   logic        pready_in;
   logic        pslverr_in;

   modport master (
      input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in,
      input  prdata_in, pready_in, pslverr_in,
      output cmd_ready_out,
      output rsp_valid_out, rsp_rdata_out, rsp_slverr_out, rsp_timeout_out,
      output psel_out, penable_out, pwrite_out, paddr_out, pwdata_out
   );

   modport slave (
      output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in,
      output prdata_in, pready_in, pslverr_in,
      input  cmd_ready_out,
      input  rsp_valid_out, rsp_rdata_out, rsp_slverr_out, rsp_timeout_out,
      input  psel_out, penable_out, pwrite_out, paddr_out, pwdata_out
   );

endinterface

// File: rtl/audioport_apb_master_watchdog.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles, flags the last allowed one.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear outside ACCESS, advance on each stalled cycle, hold at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && !expired_o)
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // cnt_q equals the number of completed stalled ACCESS cycles; the current
   // cycle is the last allowed one when TIMEOUT_CYCLES-1 have already passed.
   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/audioport_apb_master.sv
// APB3 initiator for the audioport control unit: one single-beat command in,
// one APB transfer out, one response pulse back. One transfer outstanding.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module audioport_apb_master
   import audioport_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   audioport_apb_master_if.master bus
);

   apb_state_t  state_q;
   logic        cmd_ready_q;
   logic        psel_q, penable_q, pwrite_q;
   logic [31:0] paddr_q, pwdata_q;
   logic        rsp_valid_q, rsp_slverr_q;
   logic [31:0] rsp_rdata_q;

`ifdef APB_TIMEOUT_EN
   logic wd_expired;
   logic rsp_timeout_q;

   apb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_q != ACCESS),
      .enable_i  ((state_q == ACCESS) && !bus.pready_in),
      .expired_o (wd_expired)
   );
`endif

   // Transfer FSM with all bus and response outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_slverr_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         // Response fields are only meaningful during the one-cycle pulse.
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_slverr_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
         rsp_timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               // cmd_ready_q gates acceptance so the first IDLE cycle after reset accepts nothing.
               if (bus.cmd_valid_in && cmd_ready_q) begin
                  pwrite_q    <= bus.cmd_write_in;
                  paddr_q     <= bus.cmd_addr_in;
                  pwdata_q    <= bus.cmd_wdata_in;
                  psel_q      <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  state_q     <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (bus.pready_in) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_rdata_q  <= pwrite_q ? 32'h0 : bus.prdata_in;
                  rsp_slverr_q <= bus.pslverr_in;
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  cmd_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else if (wd_expired) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_slverr_q  <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  cmd_ready_q   <= 1'b1;
                  state_q       <= IDLE;
               end
`endif
            end
            default: begin
               psel_q      <= 1'b0;
               penable_q   <= 1'b0;
               cmd_ready_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready_out  = cmd_ready_q;
   assign bus.psel_out       = psel_q;
   assign bus.penable_out    = penable_q;
   assign bus.pwrite_out     = pwrite_q;
   assign bus.paddr_out      = paddr_q;
   assign bus.pwdata_out     = pwdata_q;
   assign bus.rsp_valid_out  = rsp_valid_q;
   assign bus.rsp_rdata_out  = rsp_rdata_q;
   assign bus.rsp_slverr_out = rsp_slverr_q;
`ifdef APB_TIMEOUT_EN
   assign bus.rsp_timeout_out = rsp_timeout_q;
`else
   assign bus.rsp_timeout_out = 1'b0;
`endif

endmodule
